program_loader: RTL
===================

Name: program_loader

Overview:
- Byte-stream writer for the processor's code memory write port.
- Accepts a framed program image over a valid/ready byte interface, assembles 16-bit instruction words, and drives code_w_en/code_addr_in/code_in one word per write.
- Verifies a checksum, then raises run to release the processor.
- Sits between the host link (UART receiver or testbench) and the datapath's code-memory/run inputs.

Parameters:
ADDR_W, 9, code memory address width; max program length is 2^ADDR_W words
WORD_W, 16, instruction word width; fixed at 16 (two bytes per word, high byte first)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader can accept a byte this cycle
reload  input  1  single-cycle request to discard the current program and accept a new frame
code_w_en  output  1  code memory write enable, one cycle per word
code_addr_in  output  ADDR_W  code memory write address
code_in  output  WORD_W  code memory write data
run  output  1  processor run enable, high only after a verified load
loading  output  1  high while a frame is in progress (any state after the first length byte is accepted, through CHECK)
error  output  1  frame rejected; sticky until reload or reset

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where rx_valid && rx_ready; rx_data is sampled on that edge. rx_valid may drop between bytes at any time.
- Frame format: LEN_HI, LEN_LO (16-bit big-endian word count N), then N words as byte pairs (high, low), then CHK.
- CHK = 8-bit modular sum of every preceding byte in the frame, including both length bytes.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERR.
  - Reset state: LEN_HI.
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO -> DATA_HI on accept if 1 <= N <= 2^ADDR_W; otherwise -> ERR on the same edge.
  - DATA_HI -> DATA_LO on accept; the byte is latched as the upper half of the word.
  - DATA_LO -> WRITE on accept; the byte is latched as the lower half of the word.
  - WRITE lasts exactly one cycle. At its end the address increments; go to DATA_HI if words remain, else CHECK.
  - CHECK -> DONE on accept if the byte equals the running sum; otherwise -> ERR.
  - DONE and ERR stay put until reload, which moves to LEN_HI on the next edge and clears the sum, address and error.
- rx_ready: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK; 0 in WRITE, DONE, ERR. Bytes offered while rx_ready=0 are not consumed.
- code_w_en is 1 only in WRITE. code_addr_in and code_in are stable for the whole WRITE cycle; the memory captures them on the edge that leaves WRITE.
- Addresses start at 0 for every frame and increment by one per word. The last write uses address N-1; no wrap occurs because N <= 2^ADDR_W.
- Word counter and length register are 16 bits wide, so N = 512 fits and N > 512 is detectable.
- run: 1 only in DONE, registered. It drops on the edge that acts on reload.
- error: 1 only in ERR.
- reload in any non-DONE/ERR state also restarts the frame at LEN_HI; the partial image is abandoned and run stays 0.
- Reset values (any time, including mid-frame): state LEN_HI, code_w_en 0, code_addr_in 0, code_in 0, run 0, loading 0, error 0, rx_ready 0 while rst_n is low. After reset releases, rx_ready is 1 from the first cycle.
- Best case throughput: 3 cycles per word (2 accepts + WRITE).

Test Plan:
- Basic load: send 00 02 12 34 AB CD C0 with rx_valid held high -> two one-cycle code_w_en pulses, (addr 0, 0x1234) then (addr 1, 0xABCD); run=1 one cycle after C0 is accepted; error=0.
- Bad checksum: same frame with C1 -> both words written, error=1, run stays 0, rx_ready=0; reload pulse -> error=0, rx_ready=1, state LEN_HI.
- Length bounds:
  - 00 00 -> error=1 immediately after LEN_LO; no writes.
  - 02 01 (513) -> error=1; no writes.
  - 02 00 (512) -> 512 writes, addresses 0..511, then checksum accepted.
- Gappy source: the basic frame with random 0-5 cycle rx_valid gaps, plus a byte held valid across a WRITE cycle -> identical writes; the held byte is consumed once, after WRITE.
- Reset mid-frame: assert rst_n=0 asynchronously during DATA_LO of word 1 -> all outputs 0 immediately with no clock; after release, a full basic frame loads correctly from addr 0.
- Reload from DONE: after a successful load, pulse reload and send 00 01 FF FF FF -> run drops, a single write of 0xFFFF at addr 0, run=1 again.

Source files
------------

// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles big-endian 16-bit words into code memory,
// verifies an 8-bit additive checksum, then releases the processor via run.
module program_loader #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr_in,
    output logic [WORD_W-1:0] code_in,
    output logic              run,
    output logic              loading,
    output logic              error
);
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    state_t      state;
    logic        ready_q;
    logic [7:0]  len_hi;
    logic [7:0]  data_hi;
    logic [7:0]  sum;
    logic [15:0] rem;
    logic [16:0] n_ext;
    logic        acc;

    assign acc   = rx_valid & ready_q;
    assign n_ext = {1'b0, len_hi, rx_data};
    // ready_q resets high to match LEN_HI; gating with rst_n holds rx_ready low during reset
    assign rx_ready = rst_n & ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_LEN_HI;
            ready_q      <= 1'b1;
            len_hi       <= '0;
            data_hi      <= '0;
            sum          <= '0;
            rem          <= '0;
            code_w_en    <= 1'b0;
            code_addr_in <= '0;
            code_in      <= '0;
            run          <= 1'b0;
            loading      <= 1'b0;
            error        <= 1'b0;
        end else if (reload) begin
            state        <= S_LEN_HI;
            ready_q      <= 1'b1;
            sum          <= '0;
            code_addr_in <= '0;
            code_w_en    <= 1'b0;
            run          <= 1'b0;
            loading      <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (state)
                S_LEN_HI: if (acc) begin
                    len_hi  <= rx_data;
                    sum     <= sum + rx_data;
                    loading <= 1'b1;
                    state   <= S_LEN_LO;
                end
                S_LEN_LO: if (acc) begin
                    sum <= sum + rx_data;
                    if (n_ext != 17'd0 && n_ext <= MAX_N) begin
                        rem   <= n_ext[15:0];
                        state <= S_DATA_HI;
                    end else begin
                        error   <= 1'b1;
                        loading <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= S_ERR;
                    end
                end
                S_DATA_HI: if (acc) begin
                    data_hi <= rx_data;
                    sum     <= sum + rx_data;
                    state   <= S_DATA_LO;
                end
                S_DATA_LO: if (acc) begin
                    code_in   <= WORD_W'({data_hi, rx_data});
                    sum       <= sum + rx_data;
                    code_w_en <= 1'b1;
                    ready_q   <= 1'b0;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    code_w_en    <= 1'b0;
                    ready_q      <= 1'b1;
                    code_addr_in <= code_addr_in + 1'b1;
                    rem          <= rem - 16'd1;
                    state        <= (rem == 16'd1) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: if (acc) begin
                    loading <= 1'b0;
                    ready_q <= 1'b0;
                    if (rx_data == sum) begin
                        run   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_DONE, S_ERR: ;
                default: state <= S_LEN_HI;
            endcase
        end
    end
endmodule
